// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: request sizes, FSM states,
// beat counting and load-data extension.
package lsu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_t;

   // Only an aligned word travels as a single word beat; everything wider than
   // a byte that is not an aligned word is split into byte beats.
   function automatic logic [2:0] num_beats(input size_t size, input logic [1:0] addr_lo);
      case (size)
         SZ_BYTE: num_beats = 3'd1;
         SZ_HALF: num_beats = 3'd2;
         default: num_beats = (addr_lo == 2'b00) ? 3'd1 : 3'd4;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] data, input size_t size,
                                              input logic is_unsigned);
      case (size)
         SZ_BYTE: extend = {{(XLEN-8){data[7] & ~is_unsigned}}, data[7:0]};
         SZ_HALF: extend = {{(XLEN-16){data[15] & ~is_unsigned}}, data[15:0]};
         default: extend = data;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit.sv
// Sequences byte/word memory beats for one CPU load/store at a time and
// returns a single extended response per request.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             mem_we,
   output logic             mem_type,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata
);

   state_t           state_q, state_d;
   logic [1:0]       k_q, k_d;
   logic             we_q, we_d;
   size_t            size_q, size_d;
   logic             uns_q, uns_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [WIDTH-1:0] asm_q, asm_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             ready_q, ready_d;
   logic             resp_valid_q, resp_valid_d;
   logic             mem_we_q, mem_we_d;
   logic             mem_type_q, mem_type_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]       beats_q, beats_d;
   logic [1:0]       last_k;

   assign beats_q = num_beats(size_q, addr_q[1:0]);
   assign last_k  = beats_q[1:0] - 2'd1;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      asm_d   = asm_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = BUSY;
               k_d     = 2'd0;
               we_d    = req_we;
               size_d  = (req_size == 2'b11) ? SZ_WORD : size_t'(req_size);
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               asm_d   = '0;
            end
         end
         BUSY: begin
            // The registered mem_type tells which kind of beat is on the bus now.
            if (!we_q) begin
               if (!mem_type_q) asm_d = mem_rdata;
               else             asm_d[8*k_q +: 8] = mem_rdata[7:0];
            end
            if (k_q == last_k) begin
               state_d = RESP;
               rdata_d = we_q ? '0 : extend(asm_d, size_q, uns_q);
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus outputs are computed for the beat that will be presented next cycle.
   always_comb begin
      beats_d      = num_beats(size_d, addr_d[1:0]);
      ready_d      = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      mem_we_d     = 1'b0;
      mem_type_d   = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      if (state_d == BUSY) begin
         mem_we_d   = we_d;
         mem_addr_d = addr_d + WIDTH'(k_d);
         if (size_d == SZ_WORD && beats_d == 3'd1) begin
            mem_type_d  = 1'b0;
            mem_wdata_d = wdata_d;
         end else begin
            mem_type_d  = 1'b1;
            mem_wdata_d = {{(WIDTH-8){1'b0}}, wdata_d[8*k_d +: 8]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         k_q          <= 2'd0;
         we_q         <= 1'b0;
         size_q       <= SZ_BYTE;
         uns_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         asm_q        <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_type_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         asm_q        <= asm_d;
         rdata_q      <= rdata_d;
         ready_q      <= ready_d;
         resp_valid_q <= resp_valid_d;
         mem_we_q     <= mem_we_d;
         mem_type_q   <= mem_type_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   // Reset suppresses the write of the beat in flight so an aborted store stops at once.
   assign mem_we     = mem_we_q & ~rst;
   assign mem_type   = mem_type_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign req_ready  = ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte memory on the bus, directed test-plan cases,
// a reset-abort case and randomized requests checked against a byte-array model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic        mem_type;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [7:0]  mem     [4096];
   logic [7:0]  ref_mem [4096];
   logic        mem_clear;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_we(mem_we), .mem_type(mem_type), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Physical memory: 4 KiB window, address bits above 11 ignored.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      end else if (mem_we) begin
         if (mem_type) begin
            mem[mem_addr[11:0]] <= mem_wdata[7:0];
         end else begin
            for (int j = 0; j < 4; j++) mem[mem_addr[11:0] + 12'(j)] <= mem_wdata[8*j +: 8];
         end
      end
   end

   always_comb begin
      mem_rdata = 32'h0;
      if (mem_type) begin
         mem_rdata[7:0] = mem[mem_addr[11:0]];
      end else begin
         for (int j = 0; j < 4; j++) mem_rdata[8*j +: 8] = mem[mem_addr[11:0] + 12'(j)];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int model_bytes(input logic [1:0] size);
      if (size == 2'd0) return 1;
      if (size == 2'd1) return 2;
      return 4;
   endfunction

   function automatic int model_beats(input logic [1:0] size, input logic [31:0] addr);
      if (model_bytes(size) < 4) return model_bytes(size);
      return (addr % 4 == 0) ? 1 : 4;
   endfunction

   task automatic clear_memory();
      mem_clear = 1'b1;
      @(negedge clk);
      mem_clear = 1'b0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
   endtask

   // Called and returns at a negedge; checks every beat, the response and the hand-back.
   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got);
      int          n, nb, t;
      bit          word_beat;
      longint      val;
      logic [31:0] a, exp_r;
      n         = model_beats(size, addr);
      nb        = model_bytes(size);
      word_beat = (n == 1 && nb == 4);
      exp_r     = 32'h0;
      if (!we) begin
         val = 0;
         for (int i = 0; i < nb; i++) begin
            a   = addr + 32'(i);
            val = val + (longint'(ref_mem[a[11:0]]) << (8 * i));
         end
         if (!uns && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
            val = val - (longint'(1) << (8 * nb));
         exp_r = val[31:0];
      end else begin
         for (int i = 0; i < nb; i++) begin
            a = addr + 32'(i);
            ref_mem[a[11:0]] = wdata[8*i +: 8];
         end
      end
      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ready_before_req", {31'b0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         check("beat_addr", mem_addr, addr + 32'(i));
         check("beat_type", {31'b0, mem_type}, word_beat ? 32'd0 : 32'd1);
         check("beat_we", {31'b0, mem_we}, {31'b0, we});
         check("beat_wdata", mem_wdata, word_beat ? wdata : ((wdata >> (8 * i)) & 32'hFF));
         check("busy_ready", {31'b0, req_ready}, 32'd0);
         check("busy_resp", {31'b0, resp_valid}, 32'd0);
         @(negedge clk);
      end
      check("resp_valid", {31'b0, resp_valid}, 32'd1);
      check("resp_rdata", resp_rdata, exp_r);
      check("resp_mem_we", {31'b0, mem_we}, 32'd0);
      check("resp_mem_addr", mem_addr, 32'd0);
      check("resp_ready", {31'b0, req_ready}, 32'd0);
      got = resp_rdata;
      @(negedge clk);
      check("ready_back", {31'b0, req_ready}, 32'd1);
      check("resp_pulse", {31'b0, resp_valid}, 32'd0);
      check("rdata_hold", resp_rdata, exp_r);
      $display("txn we=%0d size=%0d uns=%0d addr=%08h wdata=%08h beats=%0d rdata=%08h",
               we, size, uns, addr, wdata, n, got);
   endtask

   initial begin
      logic [31:0] r;
      rst          = 1'b1;
      mem_clear    = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      mem_clear = 1'b0;
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_type", {31'b0, mem_type}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);

      run_req(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, r);
      check("sw_rdata_zero", r, 32'h0);
      run_req(1'b0, 2'd2, 1'b0, 32'h0001_0000, 32'h0, r);
      check("lw_back", r, 32'hDEAD_BEEF);

      run_req(1'b1, 2'd0, 1'b0, 32'h0001_0003, 32'h0000_0080, r);
      run_req(1'b0, 2'd0, 1'b0, 32'h0001_0003, 32'h0, r);
      check("lb_signed", r, 32'hFFFF_FF80);
      run_req(1'b0, 2'd0, 1'b1, 32'h0001_0003, 32'h0, r);
      check("lbu", r, 32'h0000_0080);

      run_req(1'b1, 2'd1, 1'b0, 32'h0001_0001, 32'h0000_A5C3, r);
      run_req(1'b0, 2'd1, 1'b0, 32'h0001_0001, 32'h0, r);
      check("lh_signed", r, 32'hFFFF_A5C3);
      run_req(1'b0, 2'd1, 1'b1, 32'h0001_0001, 32'h0, r);
      check("lhu", r, 32'h0000_A5C3);

      run_req(1'b1, 2'd2, 1'b0, 32'h0001_0002, 32'h1122_3344, r);
      run_req(1'b0, 2'd2, 1'b0, 32'h0001_0002, 32'h0, r);
      check("lw_misaligned", r, 32'h1122_3344);
      run_req(1'b0, 2'd3, 1'b0, 32'h0001_0002, 32'h0, r);
      check("size3_as_word", r, 32'h1122_3344);

      run_req(1'b1, 2'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0034, r);
      run_req(1'b1, 2'd0, 1'b0, 32'h0000_0000, 32'h0000_0012, r);
      run_req(1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, r);
      check("lh_wrap", r, 32'h0000_1234);

      // Abort a misaligned store during its third beat on a fresh memory.
      clear_memory();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h0001_0002;
      req_wdata = 32'h1122_3344;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_beat0", mem_addr, 32'h0001_0002);
      @(negedge clk);
      check("abort_beat1", mem_addr, 32'h0001_0003);
      @(negedge clk);
      check("abort_beat2", mem_addr, 32'h0001_0004);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_ready", {31'b0, req_ready}, 32'd1);
      check("abort_resp", {31'b0, resp_valid}, 32'd0);
      check("abort_mem_we", {31'b0, mem_we}, 32'd0);
      check("abort_mem_type", {31'b0, mem_type}, 32'd0);
      check("abort_mem_addr", mem_addr, 32'd0);
      check("abort_mem_wdata", mem_wdata, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_resp", {31'b0, resp_valid}, 32'd0);
         check("abort_no_beat", {31'b0, mem_we}, 32'd0);
      end
      check("abort_m2", {24'b0, mem[12'h002]}, 32'h44);
      check("abort_m3", {24'b0, mem[12'h003]}, 32'h33);
      check("abort_m4", {24'b0, mem[12'h004]}, 32'h00);
      check("abort_m5", {24'b0, mem[12'h005]}, 32'h00);
      ref_mem[12'h002] = 8'h44;
      ref_mem[12'h003] = 8'h33;
      $display("txn abort store addr=00010002 after 2 beats");

      // Request present during reset must not be accepted.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'd0;
      req_addr  = 32'h0001_0002;
      rst       = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      check("rstreq_ready", {31'b0, req_ready}, 32'd1);
      check("rstreq_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      check("rstreq_idle", {31'b0, req_ready}, 32'd1);
      check("rstreq_no_beat", mem_addr, 32'd0);
      $display("txn request held during reset ignored");

      for (int t = 0; t < 150; t++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                         : 32'h0001_0000 + $urandom_range(0, 31);
         run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, $urandom, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Pipeline-side initiator for the byte-addressed data memory port (byte/word `MemType`, combinational read, write on clock edge). It accepts one load/store request at a time from the CPU's memory stage and sequences the memory beats needed for byte, halfword and word accesses, splitting halfword and misaligned word accesses into byte beats. It assembles load data and sign- or zero-extends it, then returns one response per request.

## Interface
- `WIDTH`, 32, address/data width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 treated as word
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  WIDTH  byte address
- `req_wdata`  in  WIDTH  store data, LSB-aligned
- `resp_valid`  out  1  one-cycle pulse: request complete
- `resp_rdata`  out  WIDTH  extended load data; 0 for stores
- `mem_we`  out  1  memory write enable
- `mem_type`  out  1  1 = byte access, 0 = word access
- `mem_addr`  out  WIDTH  memory byte address
- `mem_wdata`  out  WIDTH  memory write data
- `mem_rdata`  in  WIDTH  memory combinational read data

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch we/size/unsigned/addr/wdata, clear the beat counter `k` and the assembly register, then go to BUSY.
- Beat count `n`:
  - byte → 1 byte beat.
  - half → 2 byte beats.
  - word with `addr[1:0]==0` → 1 word beat.
  - word otherwise → 4 byte beats.
- BUSY, one beat per cycle:
  - `mem_addr` = addr + k, modulo 2^32; wraps 0xFFFFFFFF→0x00000000.
  - Byte beat: `mem_type`=1, `mem_wdata` = {24'b0, wdata byte k}.
  - Word beat: `mem_type`=0, `mem_wdata` = wdata.
  - `mem_we` = latched we.
  - Loads capture `mem_rdata[7:0]` into assembly byte k at the beat's closing edge; a word beat captures the full `mem_rdata`.
  - After beat n-1 go to RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle.
  - `resp_rdata`: byte → bit 7 extended; half → bit 15 extended; word → unchanged. Store → 0.
  - Next state IDLE.
- Outside BUSY: `mem_we`=0, `mem_type`=0, `mem_addr`=0, `mem_wdata`=0.
- `req_valid` in BUSY/RESP is ignored. The requester holds it until `req_ready`.

## Timing
- Request accepted at edge E0. Beats occupy the n cycles after E0. `resp_valid` is high in cycle n+1 after E0. `req_ready` returns in cycle n+2.
- Issue interval per request: n+2 cycles (aligned word/byte: 3; half: 4; misaligned word: 6).
- `resp_rdata` holds its value until the next RESP. It is registered and changes only at the RESP entry edge.
- Reset values: state IDLE, `req_ready`=1 after the reset edge, `resp_valid`=0, `resp_rdata`=0, all `mem_*` outputs 0, k=0.
- Reset mid-BUSY aborts the request:
  - Beats already written stay in memory.
  - No further beats are issued and no response is produced.
  - IDLE on the next cycle.
- Reset while `req_valid` is high: the request is not accepted.

## Structure
- Package `lsu_pkg`:
  - `size_t` enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - `state_t` enum (IDLE, BUSY, RESP).
  - Function `num_beats(size, addr_lo)`.
  - Function `extend(data, size, unsigned)`.
- Single flat module; no sub-module. Beat counter is 2 bits.

## Test plan
- Store word 0xDEADBEEF at 0x00010000:
  - One beat: `mem_type`=0, `mem_we`=1, `mem_wdata`=0xDEADBEEF.
  - `resp_valid` in cycle 2 after accept, `resp_rdata`=0.
  - Load word back → 0xDEADBEEF.
- Memory byte 0x80 at 0x00010003:
  - Signed byte load → 0xFFFFFF80.
  - Unsigned byte load → 0x00000080.
- Half store 0xA5C3 at 0x00010001:
  - Beats (0x00010001, 0xC3), then (0x00010002, 0xA5), both `mem_type`=1.
  - Signed half load → 0xFFFFA5C3; unsigned → 0x0000A5C3.
- Misaligned word store 0x11223344 at 0x00010002:
  - Four byte beats at 0x00010002..0x00010005 with data 44, 33, 22, 11.
  - Load back → 0x11223344.
  - `req_ready` low for 5 cycles after accept.
- Reset asserted during beat 2 of the misaligned store above (fresh memory):
  - Only 0x00010002/0x00010003 are written.
  - No `resp_valid`.
  - `req_ready`=1 the cycle after reset.
  - All `mem_*` outputs are 0.
- Half load at 0xFFFFFFFF: beats at 0xFFFFFFFF then 0x00000000; result assembled low byte first.
